// File: rtl/display_reset_pkg.sv
// Shared definitions for the display reset-release sequencer: FSM state
// encodings (also exported on state_dbg) and default timing constants.
package display_reset_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT    = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STAGE     = 2'd2,
        ST_RELEASED  = 2'd3
    } state_e;

    localparam int DEFAULT_HOLD_CYCLES = 16;
    localparam int DEFAULT_LOCK_FILTER = 4;

endpackage

// File: rtl/reset_release_sequencer_if.sv
// Lock/soft-reset inputs and sequenced reset outputs of the reset-release
// sequencer; the sequencer takes the slave view.
interface reset_release_sequencer_if #(
    parameter int NUM_STAGES = 3
);
    logic                  pll_locked;
    logic                  soft_reset_req;
    logic [NUM_STAGES-1:0] stage_reset;
    logic                  done;
    logic [1:0]            state_dbg;

    modport master (
        output pll_locked,
        output soft_reset_req,
        input  stage_reset,
        input  done,
        input  state_dbg
    );

    modport slave (
        input  pll_locked,
        input  soft_reset_req,
        output stage_reset,
        output done,
        output state_dbg
    );
endinterface

// File: rtl/sync_ff_chain.sv
// Multi-flop synchronizer for a single asynchronous level; clears to 0 on
// the asynchronous active-low reset.
module sync_ff_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [SYNC_STAGES-1:0] sync_d;
    logic [SYNC_STAGES-1:0] sync_q;

    // Shift the raw input into the low end of the chain.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    // Synchronizer flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/reset_release_sequencer.sv
// Releases NUM_STAGES active-high reset lines in ascending order, HOLD_CYCLES
// apart, once the synchronized PLL lock has been stable for LOCK_FILTER cycles.
module reset_release_sequencer
    import display_reset_pkg::*;
#(
    parameter int NUM_STAGES    = 3,
    parameter int HOLD_CYCLES   = DEFAULT_HOLD_CYCLES,
    parameter int COUNTER_WIDTH = 5,
    parameter int SYNC_STAGES   = 2,
    parameter int LOCK_FILTER   = DEFAULT_LOCK_FILTER
) (
    input  logic                     clk_in,
    input  logic                     reset,
    reset_release_sequencer_if.slave bus
);
    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [COUNTER_WIDTH-1:0] HOLD_LAST   = COUNTER_WIDTH'(HOLD_CYCLES - 1);
    localparam logic [COUNTER_WIDTH-1:0] FILTER_LAST = COUNTER_WIDTH'(LOCK_FILTER - 1);
    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE     = COUNTER_WIDTH'(1);
    localparam logic [IDX_W-1:0]         IDX_LAST    = IDX_W'(NUM_STAGES - 1);
    localparam logic [IDX_W-1:0]         IDX_ONE     = IDX_W'(1);

    logic                     lock_s;
    logic                     abort_s;

    state_e                   state_d,       state_q;
    logic [COUNTER_WIDTH-1:0] filter_d,      filter_q;
    logic [COUNTER_WIDTH-1:0] hold_d,        hold_q;
    logic [IDX_W-1:0]         index_d,       index_q;
    logic [NUM_STAGES-1:0]    stage_reset_d, stage_reset_q;
    logic                     done_d,        done_q;

    sync_ff_chain #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk_in),
        .rst_n (reset),
        .d     (bus.pll_locked),
        .q     (lock_s)
    );

    // Lock loss or a soft request restarts sequencing from scratch.
    assign abort_s = !lock_s || bus.soft_reset_req;

    // Next-state, counter and output computation.
    always_comb begin
        state_d       = state_q;
        filter_d      = filter_q;
        hold_d        = hold_q;
        index_d       = index_q;
        stage_reset_d = stage_reset_q;
        done_d        = done_q;

        case (state_q)
            ST_ASSERT: begin
                state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK, ST_STAGE, ST_RELEASED: begin
                // Abort outranks any release falling due on this same edge.
                if (abort_s) begin
                    state_d       = ST_WAIT_LOCK;
                    filter_d      = '0;
                    hold_d        = '0;
                    index_d       = '0;
                    stage_reset_d = '1;
                    done_d        = 1'b0;
                end else if (state_q == ST_WAIT_LOCK) begin
                    if (filter_q == FILTER_LAST) begin
                        state_d  = ST_STAGE;
                        hold_d   = '0;
                        index_d  = '0;
                        filter_d = '0;
                    end else begin
                        filter_d = filter_q + CNT_ONE;
                    end
                end else if (state_q == ST_STAGE) begin
                    if (hold_q == HOLD_LAST) begin
                        stage_reset_d[index_q] = 1'b0;
                        hold_d                 = '0;
                        index_d                = index_q + IDX_ONE;
                        if (index_q == IDX_LAST) begin
                            state_d = ST_RELEASED;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_STAGE;
                        end
                    end else begin
                        hold_d = hold_q + CNT_ONE;
                    end
                end else begin
                    stage_reset_d = '0;
                    done_d        = 1'b1;
                end
            end
            default: begin
                state_d       = ST_ASSERT;
                stage_reset_d = '1;
                done_d        = 1'b0;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_ASSERT;
            filter_q      <= '0;
            hold_q        <= '0;
            index_q       <= '0;
            stage_reset_q <= '1;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            filter_q      <= filter_d;
            hold_q        <= hold_d;
            index_q       <= index_d;
            stage_reset_q <= stage_reset_d;
            done_q        <= done_d;
        end
    end

    assign bus.stage_reset = stage_reset_q;
    assign bus.done        = done_q;
    assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_reset_release_sequencer.sv
// Self-checking bench for reset_release_sequencer: directed scenarios plus
// randomized lock/soft-reset traffic against a timeline-based reference model.
module tb_reset_release_sequencer;
    localparam int NS   = 3;
    localparam int HOLD = 16;
    localparam int LF   = 4;
    localparam int SYNC = 2;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    // Reference model: stage i is released HOLD*(i+1) edges after the edge on
    // which the LOCK_FILTER-th consecutive synchronized lock sample arrives.
    bit   m_in_assert;
    int   m_run;
    int   m_start;
    int   m_n;
    bit   m_hist [SYNC];

    reset_release_sequencer_if #(.NUM_STAGES(NS)) bus();

    reset_release_sequencer #(
        .NUM_STAGES    (NS),
        .HOLD_CYCLES   (HOLD),
        .COUNTER_WIDTH (5),
        .SYNC_STAGES   (SYNC),
        .LOCK_FILTER   (LF)
    ) dut (
        .clk_in (clk),
        .reset  (rst_n),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [5:0] model_expect();
        logic [2:0] st;
        int         rel;
        st  = 3'b111;
        rel = 0;
        if (!m_in_assert && m_start >= 0) begin
            for (int i = 0; i < NS; i++) begin
                if (m_n >= m_start + (i + 1) * HOLD) begin
                    st[i] = 1'b0;
                    rel++;
                end
            end
        end
        if (m_in_assert)  return {2'd0, 1'b0, st};
        if (m_start < 0)  return {2'd1, 1'b0, st};
        if (rel == NS)    return {2'd3, 1'b1, st};
        return {2'd2, 1'b0, st};
    endfunction

    function automatic logic [5:0] observed();
        return {bus.state_dbg, bus.done, bus.stage_reset};
    endfunction

    task automatic model_reset();
        m_in_assert = 1'b1;
        m_run       = 0;
        m_start     = -1;
        m_n         = 0;
        for (int i = 0; i < SYNC; i++) m_hist[i] = 1'b0;
    endtask

    task automatic tick();
        bit ls;
        @(posedge clk);
        ls = m_hist[SYNC-1];
        for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = bus.pll_locked;
        m_n++;
        if (m_in_assert) begin
            m_in_assert = 1'b0;
            m_run       = 0;
            m_start     = -1;
        end else if (!ls || bus.soft_reset_req) begin
            m_run   = 0;
            m_start = -1;
        end else if (m_start < 0) begin
            m_run++;
            if (m_run == LF) m_start = m_n;
        end
        @(negedge clk);
    endtask

    task automatic apply_reset(input bit lock);
        rst_n              = 1'b0;
        bus.pll_locked     = lock;
        bus.soft_reset_req = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        logic [5:0] exp;
        rst_n              = 1'b0;
        bus.pll_locked     = 1'b1;
        bus.soft_reset_req = 1'b0;
        repeat (3) @(negedge clk);
        exp = {2'd0, 1'b0, 3'b111};
        tests_run++;
        if (observed() !== exp) begin
            tests_failed++;
            $display("FAIL reset_state: got %b expected %b", observed(), exp);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_power_up();
        logic [5:0] exp;
        apply_reset(1'b1);
        for (int n = 1; n <= 60; n++) begin
            tick();
            exp = model_expect();
            tests_run++;
            if (observed() !== exp) begin
                tests_failed++;
                $display("FAIL power_up_model edge %0d: got %b expected %b", n, observed(), exp);
            end
            case (n)
                1, 5:    exp = {2'd1, 1'b0, 3'b111};
                6, 21:   exp = {2'd2, 1'b0, 3'b111};
                22, 37:  exp = {2'd2, 1'b0, 3'b110};
                38, 53:  exp = {2'd2, 1'b0, 3'b100};
                54, 60:  exp = {2'd3, 1'b1, 3'b000};
                default: exp = observed();
            endcase
            if (n inside {1, 5, 6, 21, 22, 37, 38, 53, 54, 60}) begin
                tests_run++;
                if (observed() !== exp) begin
                    tests_failed++;
                    $display("FAIL power_up_timing edge %0d: got %b expected %b", n, observed(), exp);
                end
            end
        end
    endtask

    task automatic test_lock_glitch();
        apply_reset(1'b0);
        for (int k = 0; k < 48; k++) begin
            bus.pll_locked = (k % 4) != 3;
            tick();
            tests_run++;
            if (bus.stage_reset !== 3'b111 || bus.state_dbg > 2'd1 || observed() !== model_expect()) begin
                tests_failed++;
                $display("FAIL lock_glitch edge %0d: got %b expected %b", m_n, observed(), model_expect());
            end
        end
    endtask

    task automatic test_lock_loss();
        logic [5:0] exp;
        apply_reset(1'b1);
        repeat (29) tick();
        tests_run++;
        if (bus.stage_reset !== 3'b110) begin
            tests_failed++;
            $display("FAIL lock_loss_pre: got %b expected 110", bus.stage_reset);
        end
        bus.pll_locked = 1'b0;
        repeat (3) tick();
        exp = {2'd1, 1'b0, 3'b111};
        tests_run++;
        if (observed() !== exp) begin
            tests_failed++;
            $display("FAIL lock_loss_abort: got %b expected %b", observed(), exp);
        end
        repeat (3) tick();
        bus.pll_locked = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            tick();
            if (k == 21) exp = {2'd2, 1'b0, 3'b111};
            else if (k == 22) exp = {2'd2, 1'b0, 3'b110};
            else exp = model_expect();
            tests_run++;
            if (observed() !== exp || observed() !== model_expect()) begin
                tests_failed++;
                $display("FAIL lock_loss_relock k=%0d: got %b expected %b", k, observed(), exp);
            end
        end
    endtask

    task automatic test_soft_reset_released();
        logic [5:0] exp;
        apply_reset(1'b1);
        repeat (60) tick();
        bus.soft_reset_req = 1'b1;
        tick();
        bus.soft_reset_req = 1'b0;
        exp = {2'd1, 1'b0, 3'b111};
        tests_run++;
        if (observed() !== exp) begin
            tests_failed++;
            $display("FAIL soft_reset_abort: got %b expected %b", observed(), exp);
        end
        for (int k = 1; k <= LF + HOLD; k++) begin
            tick();
            if (k == LF + HOLD - 1) exp = {2'd2, 1'b0, 3'b111};
            else if (k == LF + HOLD) exp = {2'd2, 1'b0, 3'b110};
            else exp = model_expect();
            tests_run++;
            if (observed() !== exp || observed() !== model_expect()) begin
                tests_failed++;
                $display("FAIL soft_reset_rerelease k=%0d: got %b expected %b", k, observed(), exp);
            end
        end
    endtask

    task automatic test_async_reset_mid_stage();
        logic [5:0] exp;
        apply_reset(1'b1);
        repeat (30) tick();
        #2 rst_n = 1'b0;
        #1;
        exp = {2'd0, 1'b0, 3'b111};
        tests_run++;
        if (observed() !== exp) begin
            tests_failed++;
            $display("FAIL async_reset: got %b expected %b", observed(), exp);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_collision();
        logic [5:0] exp;
        apply_reset(1'b1);
        repeat (21) tick();
        bus.soft_reset_req = 1'b1;
        tick();
        bus.soft_reset_req = 1'b0;
        exp = {2'd1, 1'b0, 3'b111};
        tests_run++;
        if (observed() !== exp) begin
            tests_failed++;
            $display("FAIL collision: got %b expected %b", observed(), exp);
        end
    endtask

    task automatic test_random();
        apply_reset(1'b1);
        for (int k = 0; k < 3000; k++) begin
            bus.pll_locked     = $urandom_range(0, 99) >= 1;
            bus.soft_reset_req = $urandom_range(0, 199) == 0;
            tick();
            tests_run++;
            if (observed() !== model_expect()) begin
                tests_failed++;
                $display("FAIL random edge %0d: got %b expected %b", m_n, observed(), model_expect());
            end
        end
        bus.soft_reset_req = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        model_reset();
        test_reset();
        test_power_up();
        test_lock_glitch();
        test_lock_loss();
        test_soft_reset_released();
        test_async_reset_mid_stage();
        test_collision();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
